// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
// Sequences an external combinational AES-128 single-round key-expansion datapath.
// The block loads a cipher key, runs one expansion round per clock and stores
// all NUM_ROUNDS+1 round keys in a register file that has a random-access read port.
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   start       single-cycle expand request, accepted only in IDLE or DONE
//   key_in      cipher key, word 0 in bits [127:96]
//   rk_in_key   previous round key driven to the datapath (0 outside EXPAND)
//   rk_count    round number driven to the datapath (0 outside EXPAND)
//   rk_out_key  next round key returned by the datapath
//   busy        expansion in progress
//   done        one-cycle pulse after the last round key is written
//   keys_valid  register file holds a complete schedule for the last accepted key
//   rd_addr     round-key index to read
//   rd_key      round key at rd_addr, or 0 when rd_addr > NUM_ROUNDS
//
// NUM_ROUNDS must be in the range 1..15 so that it fits the 4-bit round count.
module key_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_W      = 128
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] rk_in_key,
  output logic [3:0]       rk_count,
  input  logic [KEY_W-1:0] rk_out_key,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rd_addr,
  output logic [KEY_W-1:0] rd_key
);

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic             done_q, done_d;
  logic             load_key0;
  logic             write_round;
  logic [KEY_W-1:0] keys_q [NUM_ROUNDS+1];

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    done_d      = 1'b0;
    load_key0   = 1'b0;
    write_round = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          load_key0 = 1'b1;
          round_d   = 4'd1;
          state_d   = StExpand;
        end
      end
      StExpand: begin
        // start is deliberately ignored here: no restart, no queueing.
        write_round = 1'b1;
        if (round_q == 4'(NUM_ROUNDS)) begin
          state_d = StDone;
          round_d = 4'd0;
          done_d  = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Round-key register file. key[0] is the cipher key; key[r] is written on
  // the edge that ends round r.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
        keys_q[i] <= '0;
      end
    end else begin
      if (load_key0) begin
        keys_q[0] <= key_in;
      end
      for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
        if (write_round && (round_q == 4'(i))) begin
          keys_q[i] <= rk_out_key;
        end
      end
    end
  end

  // Outputs.
  always_comb begin
    busy       = (state_q == StExpand);
    keys_valid = (state_q == StDone);
    done       = done_q;
    rk_count   = busy ? round_q : 4'd0;
    rk_in_key  = '0;
    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
      if (busy && (round_q == 4'(i + 1))) begin
        rk_in_key = keys_q[i];
      end
    end
  end

  // Read port: out-of-range addresses fall through to 0.
  always_comb begin
    rd_key = '0;
    for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_addr == 4'(i)) begin
        rd_key = keys_q[i];
      end
    end
  end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
- Sequencer for the AES-128 single-round key-expansion datapath. That datapath is combinational: it takes a 128-bit key and a 4-bit round count, and returns the next round key.
- This block loads the cipher key, steps the datapath through rounds 1..NUM_ROUNDS at one round per clock, and stores all round keys in an internal register file.
- The register file is read by the cipher round engine through a random-access read port.
- Sits between the top-level key input and the encrypt/decrypt round controller.

Parameters:
- NUM_ROUNDS, 10: number of expansion rounds. The register file holds NUM_ROUNDS+1 keys.
- KEY_W, 128: key and round-key width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to expand key_in. Sampled only in IDLE or DONE.
- key_in  in  KEY_W  cipher key. Bits [127:96] are word 0; bits [31:0] are word 3.
- rk_in_key  out  KEY_W  key driven to the datapath (the previous round key).
- rk_count  out  4  round number driven to the datapath.
- rk_out_key  in  KEY_W  next round key returned combinationally by the datapath.
- busy  out  1  high while expansion is in progress.
- done  out  1  one-cycle pulse when the last round key has been written.
- keys_valid  out  1  high when the register file holds a complete schedule for the last accepted key.
- rd_addr  in  4  round-key index to read, 0..NUM_ROUNDS.
- rd_key  out  KEY_W  round key at rd_addr. Combinational from registered storage.

Behaviour:
- Reset (n_rst low, asynchronous):
  - State goes to IDLE; round counter goes to 0; all NUM_ROUNDS+1 key registers clear to 0.
  - busy=0, done=0, keys_valid=0, rk_count=0, rk_in_key=0, rd_key=0.
- States: IDLE, EXPAND, DONE.
- IDLE, or DONE, with start=1 at edge T:
  - key_in is written to key[0]; the round counter is set to 1; state goes to EXPAND; keys_valid clears.
- EXPAND:
  - rk_in_key = key[r-1] and rk_count = r, where r is the round counter (1..NUM_ROUNDS).
  - Each edge writes rk_out_key to key[r] and increments r.
  - On the edge that writes key[NUM_ROUNDS], state goes to DONE, done pulses for the following cycle, and keys_valid sets.
- Latency: key[r] is written at edge T+r. done is high during cycle T+NUM_ROUNDS (after edge T+NUM_ROUNDS). Total: NUM_ROUNDS+1 edges from start to complete.
- busy:
  - High from the cycle after the start edge through the cycle in which key[NUM_ROUNDS] is written.
  - Low in IDLE and DONE.
- DONE:
  - Holds the keys; done is low after its single pulse.
  - A new start restarts expansion exactly as from IDLE and overwrites key[0] immediately.
- start while in EXPAND: ignored; no restart, no queueing.
- rk_count and rk_in_key outside EXPAND: both 0.
- rk_count width: NUM_ROUNDS must be at most 15.
- Read port:
  - rd_key = key[rd_addr] for rd_addr ≤ NUM_ROUNDS; 0 for rd_addr > NUM_ROUNDS.
  - Readable in any state. During EXPAND it may return a mix of new and stale keys; consumers must gate reads on keys_valid.
- A reset during EXPAND aborts expansion and clears everything, with no done pulse.
- key_in is sampled only at the start edge. Changes afterwards have no effect.

Test Plan:
- FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start pulse, with the real datapath attached:
  - done is seen exactly 10 cycles after the start edge.
  - rd_addr=0 returns the cipher key.
  - rd_addr=1 returns a0fafe17_88542cb1_23a33939_2a6c7605.
  - rd_addr=10 returns d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - keys_valid=1 afterwards.
- Sequencing check during the same run:
  - rk_count steps 1,2,…,10 on consecutive cycles.
  - rk_in_key equals key[r-1] each cycle.
  - busy stays high for exactly 10 cycles.
  - rk_count=0 before and after.
- Start asserted again 4 cycles into EXPAND with a different key_in:
  - Ignored; done still at cycle 10.
  - Stored keys match the first key.
- Start from DONE with key 00000000_…_0:
  - keys_valid drops on the start edge.
  - After done, rd_addr=10 returns b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- n_rst pulled low at round 5:
  - All outputs are 0 immediately (asynchronously).
  - rd_key=0 for every address.
  - No done pulse.
  - A fresh start afterwards completes normally.
- rd_addr=11..15 in any state -> rd_key=0.
